// File: rtl/tomasulo_pkg.sv
// Shared constants for the Tomasulo issue stage: opcodes, tag width, the
// "operand ready" tag and the issue controller state encoding.
package tomasulo_pkg;

    localparam int TAG_W = 3;
    localparam logic [TAG_W-1:0] TAG_READY = '0;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/issue_fifo.sv
// Circular instruction queue: storage, read/write pointers and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module issue_fifo
    import tomasulo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: only entries covered by count_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: decodes the queue head, allocates a reservation
// station slot and renames sources through the register status table.
// Define ISSUE_CTRL_PERF_EN to build the saturating stall-cycle counter.
module issue_ctrl
    import tomasulo_pkg::*;
#(
    parameter int IQ_DEPTH   = 4,
    parameter int NUM_ALU_RS = 3,
    parameter int NUM_MEM_RS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [31:0]               in_instr,
    output logic                      in_ready,
    input  logic                      flush,
    input  logic [NUM_ALU_RS-1:0]     alu_rs_busy,
    input  logic [NUM_MEM_RS-1:0]     mem_rs_busy,
    input  logic                      cdb_valid,
    input  logic [TAG_W-1:0]          cdb_tag,
    output logic                      iss_valid,
    output logic [TAG_W-1:0]          iss_tag,
    output logic                      iss_is_mem,
    output logic                      iss_is_load,
    output logic                      iss_is_mul,
    output logic [4:0]                iss_rs1,
    output logic [4:0]                iss_rs2,
    output logic [4:0]                iss_rd,
    output logic [TAG_W-1:0]          iss_qj,
    output logic [TAG_W-1:0]          iss_qk,
    output logic [$clog2(IQ_DEPTH):0] iq_count,
    output logic [15:0]               perf_stall_cnt,
    output state_t                    dbg_state
);

    state_t           state_q, state_d;
    logic [TAG_W-1:0] rst_q [32];
    logic [TAG_W-1:0] rst_d [32];

    logic [31:0]      head_instr;
    logic             head_empty, q_full, push, pop;
    logic [6:0]       opcode, funct7;
    logic             is_load, is_store, is_op, is_mem_cls, active;
    logic             head_valid, slot_free, stall_cond, issue, drop;
    logic             cdb_hit, rd_write;
    logic [TAG_W-1:0] slot_tag, qj_raw, qk_raw;
    logic             unused_funct3;

    // A flush cycle still shows in_ready; whatever is accepted is discarded.
    assign in_ready = !q_full && (state_q != ST_FLUSH);
    assign push     = in_valid && in_ready && !flush;

    issue_fifo #(.DEPTH(IQ_DEPTH), .W(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (in_instr),
        .dout_o  (head_instr),
        .empty_o (head_empty),
        .full_o  (q_full),
        .count_o (iq_count)
    );

    assign opcode        = head_instr[6:0];
    assign funct7        = head_instr[31:25];
    assign unused_funct3 = ^head_instr[14:12];
    assign is_load       = (opcode == OPC_LOAD);
    assign is_store      = (opcode == OPC_STORE);
    assign is_op         = (opcode == OPC_OP);
    assign is_mem_cls    = is_load || is_store;
    assign active        = is_mem_cls || is_op;
    assign head_valid    = !head_empty;

    // Descending scan so the lowest-index free slot is the one left standing.
    always_comb begin
        slot_free = 1'b0;
        slot_tag  = TAG_READY;
        if (is_mem_cls) begin
            for (int j = NUM_MEM_RS - 1; j >= 0; j--) begin
                if (!mem_rs_busy[j]) begin
                    slot_free = 1'b1;
                    slot_tag  = TAG_W'(NUM_ALU_RS + 1 + j);
                end
            end
        end else begin
            for (int j = NUM_ALU_RS - 1; j >= 0; j--) begin
                if (!alu_rs_busy[j]) begin
                    slot_free = 1'b1;
                    slot_tag  = TAG_W'(1 + j);
                end
            end
        end
    end

    assign stall_cond = head_valid && active && !slot_free;
    assign issue      = head_valid && active && slot_free && !flush && rst_n
                        && (state_q != ST_FLUSH);
    assign drop       = head_valid && !active && !flush && (state_q != ST_FLUSH);
    assign pop        = issue || drop;

    assign iss_valid   = issue;
    assign iss_tag     = issue ? slot_tag : TAG_READY;
    assign iss_is_mem  = is_mem_cls;
    assign iss_is_load = is_load;
    assign iss_is_mul  = is_op && (funct7 == FUNCT7_MULDIV);
    assign iss_rs1     = head_instr[19:15];
    assign iss_rs2     = head_instr[24:20];
    assign iss_rd      = head_instr[11:7];

    // A result on the CDB this cycle makes its consumers ready immediately.
    assign cdb_hit = cdb_valid && (cdb_tag != TAG_READY);
    assign qj_raw  = rst_q[iss_rs1];
    assign qk_raw  = rst_q[iss_rs2];
    assign iss_qj  = (cdb_hit && (qj_raw == cdb_tag)) ? TAG_READY : qj_raw;
    assign iss_qk  = is_load ? TAG_READY
                   : ((cdb_hit && (qk_raw == cdb_tag)) ? TAG_READY : qk_raw);

    assign rd_write = issue && (is_load || is_op) && (iss_rd != 5'd0);

    // Issue write is applied after the CDB clear so the newer producer wins.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rst_d[i] = rst_q[i];
            if (cdb_hit && (rst_q[i] == cdb_tag)) rst_d[i] = TAG_READY;
            if (rd_write && (iss_rd == 5'(i)))    rst_d[i] = slot_tag;
            if (flush)                            rst_d[i] = TAG_READY;
        end
        rst_d[0] = TAG_READY;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (!rst_n) rst_q[i] <= TAG_READY;
            else        rst_q[i] <= rst_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (stall_cond)  state_d = ST_STALL;
            ST_STALL: if (!stall_cond) state_d = ST_RUN;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (flush) state_d = ST_FLUSH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    assign dbg_state = state_q;

`ifdef ISSUE_CTRL_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if ((state_q == ST_STALL) && (perf_q != 16'hFFFF)) perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) perf_q <= 16'd0;
        else        perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: the driver pushes expected issue records into
// exp_q, a negedge monitor pops and compares whenever iss_valid is seen.
module tb_issue_ctrl;
    import tomasulo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic [2:0]  alu_rs_busy;
    logic [1:0]  mem_rs_busy;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic        iss_valid;
    logic [2:0]  iss_tag;
    logic        iss_is_mem, iss_is_load, iss_is_mul;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic [2:0]  iss_qj, iss_qk;
    logic [2:0]  iq_count;
    logic [15:0] perf_stall_cnt;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_q[$];

    issue_ctrl #(.IQ_DEPTH(4), .NUM_ALU_RS(3), .NUM_MEM_RS(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_ready       (in_ready),
        .flush          (flush),
        .alu_rs_busy    (alu_rs_busy),
        .mem_rs_busy    (mem_rs_busy),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .iss_valid      (iss_valid),
        .iss_tag        (iss_tag),
        .iss_is_mem     (iss_is_mem),
        .iss_is_load    (iss_is_load),
        .iss_is_mul     (iss_is_mul),
        .iss_rs1        (iss_rs1),
        .iss_rs2        (iss_rs2),
        .iss_rd         (iss_rd),
        .iss_qj         (iss_qj),
        .iss_qk         (iss_qk),
        .iq_count       (iq_count),
        .perf_stall_cnt (perf_stall_cnt),
        .dbg_state      (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Helpers
    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [4:0] imm);
        return {7'd0, rs2, rs1, 3'b010, imm, 7'b0100011};
    endfunction

    function automatic logic [26:0] exp_pack(input logic [2:0] tag, input logic mem,
                                             input logic ld, input logic mul,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [4:0] rd, input logic [2:0] qj,
                                             input logic [2:0] qk);
        return {tag, mem, ld, mul, rs1, rs2, rd, qj, qk};
    endfunction

    function automatic logic [31:0] perf_exp(input int n);
`ifdef ISSUE_CTRL_PERF_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst_zero(input string name);
        int nz;
        nz = 0;
        for (int i = 0; i < 32; i++) if (dut.rst_q[i] !== 3'd0) nz++;
        check(name, 32'(nz), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [26:0] act;
        logic [26:0] req;
        if (iss_valid === 1'b1) begin
            checks++;
            act = {iss_tag, iss_is_mem, iss_is_load, iss_is_mul,
                   iss_rs1, iss_rs2, iss_rd, iss_qj, iss_qk};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue actual=%0h required=no_issue", act);
            end else begin
                req = exp_q.pop_front();
                if (act !== req) begin
                    errors++;
                    $display("FAIL issue_record actual=%0h required=%0h", act, req);
                end
            end
        end
    end

    // Driver
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0;
        alu_rs_busy = '0; mem_rs_busy = '0; cdb_valid = 1'b0; cdb_tag = '0;
        tick(); tick();
        rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_iss_valid", 32'(iss_valid), 32'd0);
        check("reset_iq_count", 32'(iq_count), 32'd0);
        check("reset_perf", 32'(perf_stall_cnt), 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_RUN));
        check_rst_zero("reset_rst");

        // lw x5,0(x1) on an idle controller
        in_valid = 1'b1; in_instr = lw(5'd5, 5'd1);
        exp_q.push_back(exp_pack(3'd4, 1, 1, 0, 5'd1, 5'd0, 5'd5, 3'd0, 3'd0));
        tick();
        in_valid = 1'b0;
        tick();
        check("lw_rst5", 32'(dut.rst_q[5]), 32'd4);
        check("lw_iq_count", 32'(iq_count), 32'd0);
        cdb_valid = 1'b1; cdb_tag = 3'd4;
        tick();
        cdb_valid = 1'b0; cdb_tag = 3'd0;
        check("cdb_clear_rst5", 32'(dut.rst_q[5]), 32'd0);

        // add x3,x1,x2 then sub x4,x3,x3
        in_valid = 1'b1; in_instr = r_type(7'b0000000, 5'd2, 5'd1, 5'd3);
        exp_q.push_back(exp_pack(3'd1, 0, 0, 0, 5'd1, 5'd2, 5'd3, 3'd0, 3'd0));
        tick();
        in_instr = r_type(7'b0100000, 5'd3, 5'd3, 5'd4);
        exp_q.push_back(exp_pack(3'd2, 0, 0, 0, 5'd3, 5'd3, 5'd4, 3'd1, 3'd1));
        tick();
        in_valid = 1'b0; alu_rs_busy = 3'b001;
        tick();
        check("add_rst3", 32'(dut.rst_q[3]), 32'd1);
        check("sub_rst4", 32'(dut.rst_q[4]), 32'd2);

        // sub x6,x3,x0 issuing while the CDB broadcasts tag 1
        alu_rs_busy = 3'b011;
        in_valid = 1'b1; in_instr = r_type(7'b0100000, 5'd0, 5'd3, 5'd6);
        exp_q.push_back(exp_pack(3'd3, 0, 0, 0, 5'd3, 5'd0, 5'd6, 3'd0, 3'd0));
        tick();
        in_valid = 1'b0; cdb_valid = 1'b1; cdb_tag = 3'd1;
        tick();
        cdb_valid = 1'b0; cdb_tag = 3'd0;
        check("bypass_rst3", 32'(dut.rst_q[3]), 32'd0);
        check("bypass_rst6", 32'(dut.rst_q[6]), 32'd3);
        check("bypass_rst4", 32'(dut.rst_q[4]), 32'd2);

        // add x7,x6,x4 against a full ALU class, then release slot 2
        alu_rs_busy = 3'b111;
        in_valid = 1'b1; in_instr = r_type(7'b0000000, 5'd4, 5'd6, 5'd7);
        tick();
        in_valid = 1'b0;
        check("stall_first_state", 32'(dbg_state), 32'(ST_RUN));
        tick();
        check("stall_state", 32'(dbg_state), 32'(ST_STALL));
        check("stall_perf0", 32'(perf_stall_cnt), perf_exp(0));
        check("stall_iq_count", 32'(iq_count), 32'd1);
        tick();
        check("stall_perf1", 32'(perf_stall_cnt), perf_exp(1));
        exp_q.push_back(exp_pack(3'd2, 0, 0, 0, 5'd6, 5'd4, 5'd7, 3'd3, 3'd2));
        alu_rs_busy = 3'b101;
        tick();
        check("release_state", 32'(dbg_state), 32'(ST_RUN));
        check("release_perf2", 32'(perf_stall_cnt), perf_exp(2));
        check("release_rst7", 32'(dut.rst_q[7]), 32'd2);
        check("release_iq_count", 32'(iq_count), 32'd0);

        // Inactive opcode at the head is dropped silently
        alu_rs_busy = 3'b000;
        in_valid = 1'b1; in_instr = 32'h0000_007F;
        tick();
        in_valid = 1'b0;
        check("bad_op_count1", 32'(iq_count), 32'd1);
        tick();
        check("bad_op_count0", 32'(iq_count), 32'd0);

        // Fill the queue with every slot busy, then flush
        alu_rs_busy = 3'b111; mem_rs_busy = 2'b11;
        in_valid = 1'b1;
        in_instr = r_type(7'b0000000, 5'd2, 5'd1, 5'd10); tick();
        in_instr = lw(5'd11, 5'd1);                       tick();
        in_instr = sw(5'd2, 5'd1, 5'd4);                  tick();
        in_instr = r_type(7'b0000001, 5'd2, 5'd1, 5'd12); tick();
        check("full_iq_count", 32'(iq_count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_instr = r_type(7'b0000000, 5'd1, 5'd1, 5'd13);
        tick();
        check("full_no_push", 32'(iq_count), 32'd4);
        flush = 1'b1; alu_rs_busy = 3'b000; mem_rs_busy = 2'b00;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_iq_count", 32'(iq_count), 32'd0);
        check("flush_state", 32'(dbg_state), 32'(ST_FLUSH));
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check_rst_zero("flush_rst");
        tick();
        check("post_flush_in_ready", 32'(in_ready), 32'd1);
        check("post_flush_state", 32'(dbg_state), 32'(ST_RUN));

        // mul x8,x7,x1 then sw x8,4(x1) with MEM slot 4 busy
        mem_rs_busy = 2'b01;
        in_valid = 1'b1; in_instr = r_type(7'b0000001, 5'd1, 5'd7, 5'd8);
        exp_q.push_back(exp_pack(3'd1, 0, 0, 1, 5'd7, 5'd1, 5'd8, 3'd0, 3'd0));
        tick();
        in_instr = sw(5'd8, 5'd1, 5'd4);
        exp_q.push_back(exp_pack(3'd5, 1, 0, 0, 5'd1, 5'd8, 5'd4, 3'd0, 3'd1));
        tick();
        in_valid = 1'b0;
        tick();
        check("mul_rst8", 32'(dut.rst_q[8]), 32'd1);
        check("store_no_write", 32'(dut.rst_q[4]), 32'd0);

        // Reset while an add x9,x1,x2 sits at the head ready to issue
        mem_rs_busy = 2'b00;
        in_valid = 1'b1; in_instr = r_type(7'b0000000, 5'd2, 5'd1, 5'd9);
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_rst9", 32'(dut.rst_q[9]), 32'd0);
        check("rst_mid_rst8", 32'(dut.rst_q[8]), 32'd0);
        check("rst_mid_iq_count", 32'(iq_count), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_perf", 32'(perf_stall_cnt), 32'd0);

        tick(); tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter IQ_DEPTH, 4, instruction-queue entries (power of 2).
REQ-002 SHALL have parameter NUM_ALU_RS, 3, ALU/MUL reservation-station slots, tags 1..3.
REQ-003 SHALL have parameter NUM_MEM_RS, 2, load/store reservation-station slots, tags 4..5.
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  instruction offered.
- in_instr  in  32  RV32 instruction word.
- in_ready  out  1  queue accepts this cycle.
- flush  in  1  discard all queued and in-flight state.
- alu_rs_busy  in  NUM_ALU_RS  ALU slot occupied.
- mem_rs_busy  in  NUM_MEM_RS  MEM slot occupied.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  3  producing slot tag.
- iss_valid  out  1  issue strobe, one cycle.
- iss_tag  out  3  destination slot tag.
- iss_is_mem, iss_is_load, iss_is_mul  out  1 each  class flags.
- iss_rs1, iss_rs2, iss_rd  out  5 each  register indices.
- iss_qj, iss_qk  out  3 each  source producer tags, 0 = operand ready.
- iq_count  out  3  occupied queue entries.
- perf_stall_cnt  out  16  stall cycles.

Function
REQ-005 SHALL buffer instructions in a circular FIFO; push when in_valid && in_ready; in_ready = !full && state != FLUSH; no push-through when full.
REQ-006 SHALL decode the head entry combinationally: opcode 0000011 load, 0100011 store, 0110011 R-type (mul when funct7 = 0000001), else inactive.
REQ-007 SHALL pop an inactive head in one cycle without iss_valid.
REQ-008 SHALL issue the head combinationally (iss_valid same cycle) when the class has a free slot, choosing the lowest-index free slot; pop on that clock edge; max one issue per cycle.
REQ-009 SHALL hold the head and assert no iss_valid when the class has no free slot.
REQ-010 SHALL keep a 32-entry register status table (RST) of 3-bit tags; iss_qj/iss_qk = RST[rs1]/RST[rs2]; stores and R-type read both, loads read rs1 with iss_qk = 0.
REQ-011 SHALL on issue of load or R-type with rd != 0 write RST[rd] = iss_tag; stores and rd = 0 SHALL not write; RST[0] stays 0.
REQ-012 SHALL on cdb_valid with cdb_tag != 0 clear every RST entry equal to cdb_tag; cdb_tag 0 ignored.
REQ-013 SHALL bypass: if an issuing source tag equals a same-cycle valid cdb_tag, drive that iss_q* as 0.
REQ-014 SHALL, when CDB clear and issue write hit the same RST entry in one cycle, keep the new issue tag.
REQ-015 SHALL implement FSM RUN, STALL, FLUSH: RUN->STALL when head valid and class full; STALL->RUN when a slot frees; any->FLUSH on flush; FLUSH->RUN after one cycle.
REQ-016 SHALL on flush force iss_valid = 0, ignore in_valid, empty the queue and clear all RST entries by the next edge.
REQ-017 SHALL drive iq_count = number of valid entries, 0..IQ_DEPTH.

Reset
REQ-018 SHALL on rst_n low at an edge: queue empty, pointers 0, RST all 0, state RUN, perf_stall_cnt 0; iss_valid 0, in_ready 1 after reset.
REQ-019 SHALL treat reset mid-issue like flush: no partial RST update survives.

Configuration
REQ-020 SHALL with ISSUE_CTRL_PERF_EN defined increment perf_stall_cnt each cycle in STALL, saturating at 16'hFFFF, cleared by reset only.
REQ-021 SHALL without ISSUE_CTRL_PERF_EN tie perf_stall_cnt to 0 and synthesize no counter.

Structure
REQ-022 SHALL place opcode constants, tag width, tag 0 = READY constant and FSM state enum in shared package tomasulo_pkg.
REQ-023 SHALL instantiate one sub-module, issue_fifo, holding queue storage, pointers and count.

Verification
REQ-024 SHALL cover: push lw x5,0(x1) on idle -> next cycle iss_valid=1, iss_tag=4, iss_is_load=1, iss_qj=0, RST[5]=4.
REQ-025 SHALL cover: add x3,x1,x2 then sub x4,x3,x3 -> second issue iss_tag=2, iss_qj=iss_qk=1.
REQ-026 SHALL cover: alu_rs_busy=3'b111, push add -> no issue, state STALL, perf counter +1/cycle (macro on); release bit 1 -> issue iss_tag=2.
REQ-027 SHALL cover: issue sub reading x3 while cdb_valid=1, cdb_tag=1 -> iss_qj=0, RST[3] cleared.
REQ-028 SHALL cover: 4 pushes with all slots busy -> iq_count=4, in_ready=0; flush -> iq_count=0, RST all 0, in_ready=1 one cycle later.
REQ-029 SHALL cover: opcode 1111111 at head -> popped, iss_valid stays 0, iq_count decrements.
